// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with an accumulate mode and result flags.
// Valid/ready on both sides; a stall at the output back-propagates through in_ready.
module logic_unit_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       lu_ctl,
  input  logic             acc_en,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             zero,
  output logic             parity,
  output logic             ones
);

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NOR  = 3'd3,
    OP_NAND = 3'd4,
    OP_XNOR = 3'd5,
    OP_ANDN = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_s1;
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_z;
  logic             r_zero;
  logic             r_parity;
  logic             r_ones;
  logic             r_out_valid;

  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_f;
  logic             w_adv;
  logic             w_accept;

  // Stage 2 can take a new beat when it is empty or being drained this cycle.
  assign w_adv    = !r_out_valid || out_ready;
  assign in_ready = !r_s1_valid || w_adv;
  assign w_accept = in_valid && in_ready;

  assign w_b = acc_en ? (acc_clr ? '0 : r_acc) : B;

  // NOTE: w_f gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_f = A;
    case (op_e'(lu_ctl))
      OP_AND:  w_f = A & w_b;
      OP_OR:   w_f = A | w_b;
      OP_XOR:  w_f = A ^ w_b;
      OP_NOR:  w_f = ~(A | w_b);
      OP_NAND: w_f = ~(A & w_b);
      OP_XNOR: w_f = ~(A ^ w_b);
      OP_ANDN: w_f = A & ~w_b;
      OP_PASS: w_f = A;
      default: w_f = A;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_s1        <= '0;
      r_s1_valid  <= 1'b0;
      r_z         <= '0;
      r_zero      <= 1'b1;
      r_parity    <= 1'b0;
      r_ones      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_s1       <= w_f;
        r_s1_valid <= 1'b1;
        if (acc_en) r_acc <= w_f;
      end else if (w_adv) begin
        r_s1_valid <= 1'b0;
      end

      if (w_adv) begin
        r_out_valid <= r_s1_valid;
        // Result and flags keep their last values across bubbles.
        if (r_s1_valid) begin
          r_z      <= r_s1;
          r_zero   <= ~|r_s1;
          r_parity <= ^r_s1;
          r_ones   <= &r_s1;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign z         = r_z;
  assign zero      = r_zero;
  assign parity    = r_parity;
  assign ones      = r_ones;

endmodule

// File: doc/logic_unit_pipe.md
# logic_unit_pipe

Parametrised, pipelined successor to the 32-bit combinational logic unit: WIDTH-bit bitwise operations with eight operation codes, an accumulate mode that chains results across beats, and result flags. Valid/ready handshakes on input and output, fixed two-cycle latency, full throughput under backpressure. Sits between the ALU operand-issue stage and the ALU result mux; lu_ctl codes 0-3 keep the existing AND/OR/XOR/NOR encoding.

## Interface
- WIDTH, 32, operand and result width (>= 2)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; one clock, reset synchronous and active-high
- in_valid  in  1  input beat offered
- in_ready  out  1  input beat accepted when in_valid & in_ready
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B (ignored when acc_en=1)
- lu_ctl  in  3  operation select
- acc_en  in  1  use accumulator in place of B
- acc_clr  in  1  treat accumulator as 0 for this beat (only meaningful with acc_en)
- out_valid  out  1  result beat offered
- out_ready  in  1  result beat consumed when out_valid & out_ready
- z  out  WIDTH  result
- zero  out  1  z == 0
- parity  out  1  XOR-reduction of z
- ones  out  1  z all ones

## Operation
- Opcodes: 000 AND, 001 OR, 010 XOR, 011 NOR, 100 NAND, 101 XNOR, 110 ANDN (A & ~B'), 111 PASS (A).
- B' = acc_en ? (acc_clr ? 0 : acc) : B.
- Stage 1 (on accept): r1 = f(lu_ctl, A, B'), s1_valid set. Accumulator acc <= r1 on every accepted beat with acc_en=1; beats with acc_en=0 leave acc unchanged.
- acc is updated at accept time, so back-to-back chained beats see the immediately preceding chained result; no hazard, no stall.
- Stage 2: z <= r1; zero/parity/ones computed from r1 and registered with z; out_valid set.
- Stage 1 advances into stage 2 when !out_valid | out_ready.
- in_ready = !s1_valid | !out_valid | out_ready (combinational from out_ready permitted).
- Holding: while out_valid & !out_ready, z and flags are stable. Input A/B/lu_ctl are not required to hold after acceptance.
- Beats leave in acceptance order; none dropped or duplicated.

## Timing
- Reset (rst=1 at edge): s1_valid=0, out_valid=0, z=0, zero=1, parity=0, ones=0, acc=0; in_ready=1 in the cycle after reset. rst overrides any simultaneous accept or consume; an in-flight beat is discarded.
- Latency: beat accepted at edge N appears with out_valid=1 after edge N+1 when unstalled.
- Throughput: one beat per cycle with out_ready held high.
- Full: both stages valid and out_ready=0 -> in_ready=0; no state changes.
- Simultaneous consume and accept with both stages full: stage 2 takes stage 1, stage 1 takes new beat, same edge.
- Empty: out_valid=0; z/flags hold last values (no reset to 0 between beats).
- acc_clr with acc_en=0: ignored.

## Test plan
- WIDTH=32, out_ready=1, back-to-back opcodes 0-7 with A=0xF0F0_00FF, B=0x0FF0_0F0F -> z = 0x00F0_000F, 0xFFF0_0FFF, 0xFF00_0FF0, 0x000F_F000, 0xFF0F_FFF0, 0x00FF_F00F, 0xF000_00F0, 0xF0F0_00FF on consecutive cycles, first two cycles after first accept.
- Flags: AND of 0xAAAA_AAAA, 0x5555_5555 -> z=0, zero=1, parity=0; XOR same -> z=0xFFFF_FFFF, ones=1, parity=0; PASS A=1 -> parity=1.
- Accumulate: beat1 OR, acc_en=1, acc_clr=1, A=0x1 -> z=0x1; beat2 OR, acc_en=1, A=0x2 -> 0x3; beat3 XOR, acc_en=1, A=0x1 -> 0x2; intervening acc_en=0 beat leaves acc=0x2.
- Backpressure: out_ready=0 while issuing 3 beats -> 2 accepted, in_ready=0 on 3rd, z holds first result; release out_ready -> all 3 results in order, no loss.
- Reset mid-flight: two beats in pipeline, acc=0x3, rst=1 one cycle -> out_valid=0, z=0, zero=1, acc=0; next acc_en beat OR A=0x4 -> z=0x4.
- Random: 10k beats, random in_valid/out_ready/ops/acc_en against a reference model; compare z and flags.
